// File: rtl/tdc_tag_buffer_if.sv
// Readout-side stream for tdc_tag_buffer: head tag plus valid/ready handshake.
// master = tag buffer (drives valid and head data), slave = consumer (drives ready).
interface tdc_tag_buffer_if;
    logic        valid;
    logic        ready;
    logic [31:0] utc;
    logic [27:0] coarse;
    logic [12:0] frac;
    logic [15:0] seq;

    modport master (output valid, utc, coarse, frac, seq, input ready);
    modport slave  (input valid, utc, coarse, frac, seq, output ready);
endinterface

// File: rtl/tdc_tag_buffer.sv
// Ring buffer for timestamper tags. Each stored tag is stamped with a 16-bit
// sequence number and presented through a registered head on a valid/ready stream.
// Tags arriving while full (with no same-cycle pop) are counted as overflow.
// Optional macro FD_TAG_BUF_DEADTIME_EN adds a minimum-spacing filter that
// silently rejects tags closer than g_dead_time coarse ticks to the last stored tag.
module tdc_tag_buffer #(
    parameter int g_depth        = 64,
    parameter int g_coarse_range = 125000000,
    parameter int g_dead_time    = 16
) (
    input  logic                     clk_ref_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     tag_valid_p1_i,
    input  logic [31:0]              tag_utc_i,
    input  logic [27:0]              tag_coarse_i,
    input  logic [12:0]              tag_frac_i,
    tdc_tag_buffer_if.master         out_if,
    output logic [$clog2(g_depth):0] count_o,
    output logic [15:0]              overflow_cnt_o,
    output logic                     overflow_p1_o
);
    localparam int c_aw = $clog2(g_depth);
    localparam logic [c_aw:0] c_full = (c_aw + 1)'(g_depth);

    typedef struct packed {
        logic [31:0] utc;
        logic [27:0] coarse;
        logic [12:0] frac;
        logic [15:0] seq;
    } entry_t;

    entry_t          mem [g_depth];
    entry_t          head;
    entry_t          new_entry;
    logic [c_aw-1:0] wr_ptr;
    logic [c_aw-1:0] rd_ptr;
    logic [c_aw-1:0] rd_next;
    logic [c_aw:0]   held_after_pop;
    logic [15:0]     seq;
    logic            full;
    logic            pop;
    logic            candidate;
    logic            push;
    logic            drop;
    logic            tag_ok;

    assign full           = (count_o == c_full);
    assign pop            = out_if.valid & out_if.ready;
    assign candidate      = tag_valid_p1_i & enable_i & tag_ok & ~clear_i;
    assign push           = candidate & (~full | pop);
    assign drop           = candidate & full & ~pop;
    assign rd_next        = rd_ptr + {{(c_aw-1){1'b0}}, pop};
    assign held_after_pop = count_o - {{c_aw{1'b0}}, pop};
    assign new_entry      = '{utc: tag_utc_i, coarse: tag_coarse_i, frac: tag_frac_i, seq: seq};

    assign out_if.valid  = (count_o != '0);
    assign out_if.utc    = head.utc;
    assign out_if.coarse = head.coarse;
    assign out_if.frac   = head.frac;
    assign out_if.seq    = head.seq;

`ifdef FD_TAG_BUF_DEADTIME_EN
    logic        have_last;
    logic [31:0] last_utc;
    logic [27:0] last_coarse;
    logic [31:0] utc_delta;
    logic [31:0] dist;

    // Spacing filter: distance only meaningful when the UTC delta is 0 or 1.
    always_comb begin
        utc_delta = tag_utc_i - last_utc;
        dist      = '0;
        tag_ok    = 1'b1;
        if (have_last && utc_delta < 32'd2) begin
            dist   = ((utc_delta == 32'd1) ? 32'(g_coarse_range) : 32'd0)
                   + {4'b0, tag_coarse_i} - {4'b0, last_coarse};
            tag_ok = (dist >= 32'(g_dead_time));
        end
    end

    // Remember the last stored tag; forgotten on reset/clear so the next tag always passes.
    always_ff @(posedge clk_ref_i) begin
        if (rst_i || clear_i) begin
            have_last   <= 1'b0;
            last_utc    <= '0;
            last_coarse <= '0;
        end else if (push) begin
            have_last   <= 1'b1;
            last_utc    <= tag_utc_i;
            last_coarse <= tag_coarse_i;
        end
    end
`else
    assign tag_ok = 1'b1;
`endif

    // Storage write port.
    // NOTE: the entry array has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_ref_i) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Pointers, occupancy, sequence and overflow accounting.
    always_ff @(posedge clk_ref_i) begin
        if (rst_i || clear_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_o        <= '0;
            seq            <= '0;
            overflow_cnt_o <= '0;
            overflow_p1_o  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 16'd1;
            end
            rd_ptr        <= rd_next;
            count_o       <= count_o + {{c_aw{1'b0}}, push} - {{c_aw{1'b0}}, pop};
            overflow_p1_o <= drop;
            if (drop && overflow_cnt_o != 16'hFFFF) begin
                overflow_cnt_o <= overflow_cnt_o + 16'd1;
            end
        end
    end

    // Head register: next stored entry, or the incoming tag bypassed when the buffer drains to empty.
    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            head <= '0;
        end else if (!clear_i) begin
            if (held_after_pop != '0) begin
                head <= mem[rd_next];
            end else if (push) begin
                head <= new_entry;
            end
        end
    end
endmodule

// File: tb/tb_tdc_tag_buffer.sv
// Directed self-checking bench for tdc_tag_buffer (g_depth = 64).
module tb_tdc_tag_buffer;
    logic        clk_ref_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        clear_i;
    logic        tag_valid_p1_i;
    logic [31:0] tag_utc_i;
    logic [27:0] tag_coarse_i;
    logic [12:0] tag_frac_i;
    logic [6:0]  count_o;
    logic [15:0] overflow_cnt_o;
    logic        overflow_p1_o;

    int vectors     = 0;
    int miscompares = 0;
    int pulses;

    tdc_tag_buffer_if out_bus ();

    tdc_tag_buffer #(.g_depth(64), .g_coarse_range(125000000), .g_dead_time(16)) dut (
        .clk_ref_i      (clk_ref_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .clear_i        (clear_i),
        .tag_valid_p1_i (tag_valid_p1_i),
        .tag_utc_i      (tag_utc_i),
        .tag_coarse_i   (tag_coarse_i),
        .tag_frac_i     (tag_frac_i),
        .out_if         (out_bus),
        .count_o        (count_o),
        .overflow_cnt_o (overflow_cnt_o),
        .overflow_p1_o  (overflow_p1_o)
    );

    always #5 clk_ref_i = ~clk_ref_i;

    task automatic tick();
        @(posedge clk_ref_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic strobe(input logic [31:0] utc, input logic [27:0] coarse, input logic [12:0] frac);
        tag_utc_i      = utc;
        tag_coarse_i   = coarse;
        tag_frac_i     = frac;
        tag_valid_p1_i = 1'b1;
        tick();
        tag_valid_p1_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b1; clear_i = 1'b0; tag_valid_p1_i = 1'b0;
        tag_utc_i = '0; tag_coarse_i = '0; tag_frac_i = '0; out_bus.ready = 1'b0;
        do_reset();

        // reset state
        check("rst_count", 32'(count_o), 0);
        check("rst_valid", 32'(out_bus.valid), 0);
        check("rst_ovf_cnt", 32'(overflow_cnt_o), 0);
        check("rst_ovf_p1", 32'(overflow_p1_o), 0);
        check("rst_utc", out_bus.utc, 0);
        check("rst_seq", 32'(out_bus.seq), 0);

        // 1: single tag, visible next cycle, then popped
        strobe(32'd5, 28'd100, 13'd7);
        check("t1_valid", 32'(out_bus.valid), 1);
        check("t1_utc", out_bus.utc, 5);
        check("t1_coarse", 32'(out_bus.coarse), 100);
        check("t1_frac", 32'(out_bus.frac), 7);
        check("t1_seq", 32'(out_bus.seq), 0);
        check("t1_count", 32'(count_o), 1);
        out_bus.ready = 1'b1;
        tick();
        out_bus.ready = 1'b0;
        check("t1_count_pop", 32'(count_o), 0);
        check("t1_valid_pop", 32'(out_bus.valid), 0);
        check("t1_utc_hold", out_bus.utc, 5);
        out_bus.ready = 1'b1;
        tick();
        out_bus.ready = 1'b0;
        check("t1_ready_empty", 32'(count_o), 0);

        // 2: 70 tags into 64 entries with no reads
        do_reset();
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            strobe(32'(100 + i), 28'd50, 13'(i));
            if (overflow_p1_o) pulses++;
        end
        tick();
        check("t2_ovf_p1_idle", 32'(overflow_p1_o), 0);
        check("t2_count", 32'(count_o), 64);
        check("t2_ovf_cnt", 32'(overflow_cnt_o), 6);
        check("t2_pulses", 32'(pulses), 6);
        check("t2_head_seq", 32'(out_bus.seq), 0);
        check("t2_head_utc", out_bus.utc, 100);

        // 3: push into full buffer with same-cycle pop
        out_bus.ready = 1'b1;
        strobe(32'd999, 28'd50, 13'd1);
        out_bus.ready = 1'b0;
        check("t3_count", 32'(count_o), 64);
        check("t3_ovf_cnt", 32'(overflow_cnt_o), 6);
        check("t3_ovf_p1", 32'(overflow_p1_o), 0);
        // drain: remaining seq 1..63 then the tag stored in step 3 as seq 64
        out_bus.ready = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            check("t3_drain_valid", 32'(out_bus.valid), 1);
            check("t3_drain_seq", 32'(out_bus.seq), 32'(k));
            check("t3_drain_utc", out_bus.utc, (k < 64) ? 32'(100 + k) : 32'd999);
            tick();
        end
        out_bus.ready = 1'b0;
        check("t3_empty_count", 32'(count_o), 0);
        check("t3_empty_valid", 32'(out_bus.valid), 0);

        // 4: clear together with a tag while holding 10 entries
        for (int i = 0; i < 10; i++) strobe(32'(2000 + i), 28'd50, 13'd2);
        check("t4_count10", 32'(count_o), 10);
        clear_i = 1'b1;
        strobe(32'd2100, 28'd50, 13'd3);
        clear_i = 1'b0;
        check("t4_count", 32'(count_o), 0);
        check("t4_valid", 32'(out_bus.valid), 0);
        check("t4_ovf_cnt", 32'(overflow_cnt_o), 0);
        check("t4_ovf_p1", 32'(overflow_p1_o), 0);
        strobe(32'd2200, 28'd60, 13'd4);
        check("t4_next_seq", 32'(out_bus.seq), 0);
        check("t4_next_utc", out_bus.utc, 2200);
        check("t4_next_count", 32'(count_o), 1);

        // enable low: strobes ignored
        enable_i = 1'b0;
        strobe(32'd2300, 28'd60, 13'd4);
        enable_i = 1'b1;
        check("en_off_count", 32'(count_o), 1);

        // 6: stall with 3 entries, then reset mid-stream
        do_reset();
        strobe(32'd3000, 28'd11, 13'd21);
        strobe(32'd3001, 28'd12, 13'd22);
        strobe(32'd3002, 28'd13, 13'd23);
        for (int c = 0; c < 20; c++) begin
            check("t6_stall_utc", out_bus.utc, 3000);
            check("t6_stall_coarse", 32'(out_bus.coarse), 11);
            check("t6_stall_seq", 32'(out_bus.seq), 0);
            tick();
        end
        check("t6_count", 32'(count_o), 3);
        // pop once: next entry with no bubble
        out_bus.ready = 1'b1;
        tick();
        out_bus.ready = 1'b0;
        check("t6_pop_utc", out_bus.utc, 3001);
        check("t6_pop_seq", 32'(out_bus.seq), 1);
        check("t6_pop_valid", 32'(out_bus.valid), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t6_rst_valid", 32'(out_bus.valid), 0);
        check("t6_rst_count", 32'(count_o), 0);

`ifdef FD_TAG_BUF_DEADTIME_EN
        // 5: dead-time filter
        do_reset();
        strobe(32'd0, 28'd1000, 13'd0);
        strobe(32'd0, 28'd1010, 13'd0);
        check("t5_reject_count", 32'(count_o), 1);
        strobe(32'd0, 28'd1016, 13'd0);
        check("t5_accept_count", 32'(count_o), 2);
        strobe(32'd3, 28'd124999995, 13'd0);
        check("t5_far_count", 32'(count_o), 3);
        strobe(32'd4, 28'd5, 13'd0);
        check("t5_wrap_count", 32'(count_o), 3);
        check("t5_ovf_cnt", 32'(overflow_cnt_o), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
